// File: rtl/skid_register.sv
// ============================================================================
// Module      : skid_register
// Description : Elastic valid/ready pipeline register with a one-entry skid
//               buffer; all outputs registered, 1 transfer/cycle sustained.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_busy  = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid;
    logic             r_out_valid;
    logic             r_in_ready;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_out_data_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_in_fire;
    logic             w_out_fire;

    assign w_in_fire  = in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_out_data_nxt = r_out_data;
        w_skid_nxt     = r_skid;
        case (r_state)
            c_st_empty: begin
                if (w_in_fire) begin
                    w_out_data_nxt = in_data;
                    w_state_nxt    = c_st_busy;
                end
            end
            c_st_busy: begin
                if (w_in_fire && w_out_fire) begin
                    w_out_data_nxt = in_data;
                end else if (w_in_fire) begin
                    // Downstream stalled: park the new item behind the output
                    w_skid_nxt  = in_data;
                    w_state_nxt = c_st_full;
                end else if (w_out_fire) begin
                    w_state_nxt = c_st_empty;
                end
            end
            c_st_full: begin
                if (out_ready) begin
                    w_out_data_nxt = r_skid;
                    w_state_nxt    = c_st_busy;
                end
            end
            default: begin
                w_state_nxt = c_st_empty;
            end
        endcase
    end

    // Handshake flags are precomputed from the next state so they leave flops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_empty;
            r_out_data  <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_data  <= w_out_data_nxt;
            r_skid      <= w_skid_nxt;
            r_out_valid <= (w_state_nxt != c_st_empty);
            r_in_ready  <= (w_state_nxt != c_st_full);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_skid_register.sv
// ============================================================================
// Module      : tb_skid_register
// Description : Directed and random scoreboard bench for skid_register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_skid_register;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] q[$];
    logic             last_rst = 1'b1;

    skid_register #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with inputs already driven; checks outputs against
    // the queue model, then advances the model and the clock by one cycle.
    task automatic cycle(input string tag);
        logic exp_rdy;
        logic exp_vld;
        logic in_fire;
        logic out_fire;
        exp_rdy = !last_rst && (q.size() < 2);
        exp_vld = !last_rst && (q.size() > 0);
        check({tag, ".in_ready"},  {{(WIDTH-1){1'b0}}, in_ready},  {{(WIDTH-1){1'b0}}, exp_rdy});
        check({tag, ".out_valid"}, {{(WIDTH-1){1'b0}}, out_valid}, {{(WIDTH-1){1'b0}}, exp_vld});
        if (exp_vld) check({tag, ".out_data"}, out_data, q[0]);
        in_fire  = !rst && in_valid && exp_rdy;
        out_fire = !rst && exp_vld && out_ready;
        if (rst) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back(in_data);
        end
        last_rst = rst;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset with an item offered that must not be captured
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h01; out_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) cycle("reset");
        check("reset.out_data", out_data, 8'h00);
        rst = 1'b0; in_valid = 1'b0;
        cycle("release");
        cycle("release_ready");

        // Pass-through at full rate
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 8'h10; cycle("pass");
        in_data = 8'h11; cycle("pass");
        in_data = 8'h12; cycle("pass");
        in_valid = 1'b0;
        cycle("pass_tail");
        cycle("pass_tail");

        // Backpressure fill, then A2 offered while full
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hA0; cycle("fill");
        in_data = 8'hA1; cycle("fill");
        in_data = 8'hA2; cycle("full_hold");
        cycle("full_hold");
        cycle("full_hold");

        // Drain with A2 still offered
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle("drain");
        in_valid = 1'b0;
        cycle("drain_tail");
        cycle("drain_tail");

        // Reset while full discards B0/B1
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hB0; cycle("mid_fill");
        in_data = 8'hB1; cycle("mid_fill");
        in_valid = 1'b0;
        cycle("mid_full");
        rst = 1'b1;
        cycle("mid_rst");
        rst = 1'b0; out_ready = 1'b1;
        cycle("mid_release");
        cycle("mid_after");
        cycle("mid_after");

        // Random soak
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            in_data   = WIDTH'($urandom);
            cycle("soak");
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle("soak_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
